group_update_sequencer: RTL and testbench
=========================================

// Module: group_update_sequencer
// PURPOSE
// Drives the 3-bit group select of the grouped p-bit update-order LUT.
// Steps through graph-colour groups 0..NUM_GROUPS-1 in order, holding each group for a programmable dwell.
// One complete pass over all groups is one sweep; a run is N sweeps or free-running.
// Sits between the run controller (start/stop, config) and the LUT.
// The LUT output Pbit_EN is ANDed with group_valid before reaching the p-bit array.
// PARAMETERS
// NUM_GROUPS  5   number of groups; legal group codes are 0..NUM_GROUPS-1
// GROUP_W     3   width of group_EN; 2**GROUP_W >= NUM_GROUPS
// DWELL_W     8   width of dwell_cycles
// SWEEP_W     16  width of num_sweeps and sweep_count
// PORTS
// clk           in   1        system clock, rising edge
// rst_n         in   1        asynchronous active-low reset
// start         in   1        1-cycle request to begin a run; sampled only in IDLE
// stop          in   1        request graceful stop at end of the current sweep
// dwell_cycles  in   DWELL_W  extra hold cycles per group; sampled at start
// num_sweeps    in   SWEEP_W  sweeps per run, 0 = free-run until stop; sampled at start
// group_EN      out  GROUP_W  current group code, driven to the LUT
// group_valid   out  1        group_EN is live; p-bit enables are gated with this
// sweep_done    out  1        1-cycle pulse in the last cycle of each sweep
// done          out  1        1-cycle pulse in the cycle after the final sweep ends
// busy          out  1        high in RUN and FINISH
// sweep_count   out  SWEEP_W  completed sweeps this run; saturates at all-ones
// BEHAVIOUR
// - Reset: state=IDLE. Outputs group_EN=0, group_valid=0, sweep_done=0, done=0, busy=0, sweep_count=0.
// - States: IDLE, RUN, FINISH. All outputs are registered.
// - IDLE + start: latch dwell_cycles and num_sweeps, clear sweep_count and stop_pending, go to RUN.
//   - First RUN cycle: group_EN=0, group_valid=1. Latency start->valid is 1 cycle.
// - IDLE: stop is ignored. start+stop in the same cycle is treated as start only.
// - RUN: each group is held for dwell+1 cycles (dwell=0 gives 1 cycle per group).
//   - The dwell counter counts up from 0. At dwell it resets and group_EN advances.
//   - After group NUM_GROUPS-1, group_EN wraps to 0.
//   - Codes >= NUM_GROUPS are never driven, so the LUT never sees an undefined select.
// - sweep_done is asserted in the final dwell cycle of group NUM_GROUPS-1.
//   - sweep_count increments on that same edge; the new value is visible with group 0.
// - stop in RUN sets a sticky stop_pending. The run ends at the next sweep_done, never mid-sweep.
//   - Every p-bit therefore receives the same number of updates.
// - The run ends at sweep_done when either holds:
//   - num_sweeps!=0 and sweep_count+1==num_sweeps, or
//   - stop_pending (including stop asserted on the sweep_done cycle itself).
//   - On end: go to FINISH. group_valid=0 and group_EN=0 from the next cycle.
// - FINISH lasts 1 cycle: done=1, busy=1, then IDLE.
//   - sweep_count holds its final value until the next start.
// - start during RUN or FINISH is ignored. No queuing.
// - Free-run (num_sweeps=0): sweep_count saturates at all-ones and does not wrap; the run continues until stop.
// - Config inputs changing mid-run have no effect.
// - rst_n low mid-run: immediate return to reset values, no done pulse.
// TESTING
// T1 reset with rst_n low -> all outputs 0; release, no start -> stays IDLE for 20 cycles.
// T2 start, dwell=0, num_sweeps=2
//    -> group_EN 0,1,2,3,4,0,1,2,3,4; valid high for exactly 10 cycles;
//    -> sweep_done pulses at cycles 5 and 10; done at cycle 11; sweep_count=2.
// T3 dwell=2, num_sweeps=1 -> each group held 3 cycles; 15 valid cycles; done on cycle 16.
// T4 num_sweeps=0, stop asserted during group 2 of sweep 3
//    -> sweep 3 completes through group 4; done follows; sweep_count=3.
// T5 start pulsed while busy, and start+stop together in IDLE
//    -> the first is ignored; the second begins a normal run.
// T6 rst_n asserted during group 3 of a run -> outputs 0 asynchronously; no done; a new start runs normally.
// T7 assertion: group_EN < NUM_GROUPS always; group_valid implies busy.

Source files
------------

// File: rtl/group_update_sequencer_if.sv
// Control/status bundle between the run controller and the group update sequencer.
// Latency: none, wires only.
// Backpressure: none; start/stop are level-sampled requests, outputs are always valid.
interface group_update_sequencer_if #(
    parameter int GROUP_W = 3,
    parameter int DWELL_W = 8,
    parameter int SWEEP_W = 16
);
    logic               start;
    logic               stop;
    logic [DWELL_W-1:0] dwell_cycles;
    logic [SWEEP_W-1:0] num_sweeps;
    logic [GROUP_W-1:0] group_EN;
    logic               group_valid;
    logic               sweep_done;
    logic               done;
    logic               busy;
    logic [SWEEP_W-1:0] sweep_count;

    // Run controller side
    modport master (
        output start, stop, dwell_cycles, num_sweeps,
        input  group_EN, group_valid, sweep_done, done, busy, sweep_count
    );

    // Sequencer side
    modport slave (
        input  start, stop, dwell_cycles, num_sweeps,
        output group_EN, group_valid, sweep_done, done, busy, sweep_count
    );
endinterface

// File: rtl/group_update_sequencer.sv
// Steps the LUT group select through colour groups 0..NUM_GROUPS-1, holding each dwell+1 cycles, for N sweeps or until stop.
// Latency: start to first valid group is 1 cycle; done pulses 1 cycle after the final sweep's last cycle.
// Backpressure: none; stop is deferred to the end of the current sweep, start is ignored unless idle.
module group_update_sequencer #(
    parameter int NUM_GROUPS = 5,
    parameter int GROUP_W    = 3,
    parameter int DWELL_W    = 8,
    parameter int SWEEP_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    group_update_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [GROUP_W-1:0] LAST_GROUP = GROUP_W'(NUM_GROUPS - 1);

    state_t             state_q, state_d;
    logic [GROUP_W-1:0] group_q, group_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [DWELL_W-1:0] dwell_cfg_q, dwell_cfg_d;
    logic [SWEEP_W-1:0] num_sweeps_q, num_sweeps_d;
    logic [SWEEP_W-1:0] sweep_count_q, sweep_count_d;
    logic               stop_pending_q, stop_pending_d;
    logic               group_valid_q, group_valid_d;
    logic               sweep_done_q, sweep_done_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               run_end;

    // Next-state and next-output computation; outputs are derived from the
    // next state so that every output is a flop with no decode after it.
    always_comb begin
        state_d        = state_q;
        group_d        = group_q;
        dwell_cnt_d    = dwell_cnt_q;
        dwell_cfg_d    = dwell_cfg_q;
        num_sweeps_d   = num_sweeps_q;
        sweep_count_d  = sweep_count_q;
        stop_pending_d = stop_pending_q;
        run_end        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // stop is meaningless here; start+stop is just a start
                if (bus.start) begin
                    state_d        = S_RUN;
                    group_d        = '0;
                    dwell_cnt_d    = '0;
                    dwell_cfg_d    = bus.dwell_cycles;
                    num_sweeps_d   = bus.num_sweeps;
                    sweep_count_d  = '0;
                    stop_pending_d = 1'b0;
                end
            end

            S_RUN: begin
                if (bus.stop) begin
                    stop_pending_d = 1'b1;
                end
                if (dwell_cnt_q == dwell_cfg_q) begin
                    dwell_cnt_d = '0;
                    if (group_q == LAST_GROUP) begin
                        // Sweep boundary: the only place a run may end, so
                        // every p-bit sees the same number of updates.
                        group_d = '0;
                        if (sweep_count_q != '1) begin
                            sweep_count_d = sweep_count_q + SWEEP_W'(1);
                        end
                        run_end = stop_pending_q || bus.stop ||
                                  ((num_sweeps_q != '0) &&
                                   ((sweep_count_q + SWEEP_W'(1)) == num_sweeps_q));
                        if (run_end) begin
                            state_d = S_FINISH;
                        end
                    end else begin
                        group_d = group_q + GROUP_W'(1);
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                group_d = '0;
            end
        endcase

        group_valid_d = (state_d == S_RUN);
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_FINISH);
        sweep_done_d  = (state_d == S_RUN) && (group_d == LAST_GROUP) &&
                        (dwell_cnt_d == dwell_cfg_d);
    end

    // State and registered outputs; reset returns everything to idle with no done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            group_q        <= '0;
            dwell_cnt_q    <= '0;
            dwell_cfg_q    <= '0;
            num_sweeps_q   <= '0;
            sweep_count_q  <= '0;
            stop_pending_q <= 1'b0;
            group_valid_q  <= 1'b0;
            sweep_done_q   <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            group_q        <= group_d;
            dwell_cnt_q    <= dwell_cnt_d;
            dwell_cfg_q    <= dwell_cfg_d;
            num_sweeps_q   <= num_sweeps_d;
            sweep_count_q  <= sweep_count_d;
            stop_pending_q <= stop_pending_d;
            group_valid_q  <= group_valid_d;
            sweep_done_q   <= sweep_done_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.group_EN    = group_q;
    assign bus.group_valid = group_valid_q;
    assign bus.sweep_done  = sweep_done_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.sweep_count = sweep_count_q;

endmodule

// File: tb/tb_group_update_sequencer.sv
// Randomized self-checking bench for group_update_sequencer against a sweep-arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_group_update_sequencer;

    localparam int NG      = 5;
    localparam int GROUP_W = 3;
    localparam int DWELL_W = 8;
    localparam int SWEEP_W = 16;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    group_update_sequencer_if #(.GROUP_W(GROUP_W), .DWELL_W(DWELL_W), .SWEEP_W(SWEEP_W)) bus ();

    group_update_sequencer #(
        .NUM_GROUPS(NG), .GROUP_W(GROUP_W), .DWELL_W(DWELL_W), .SWEEP_W(SWEEP_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Observed outputs packed as {group_EN, valid, sweep_done, done, busy, sweep_count}
    function automatic logic [22:0] observed();
        return {bus.group_EN, bus.group_valid, bus.sweep_done, bus.done, bus.busy, bus.sweep_count};
    endfunction

    function automatic logic [22:0] pack(input int grp, input bit vld, input bit sd,
                                         input bit dn, input bit bsy, input logic [15:0] cnt);
        return {GROUP_W'(grp), vld, sd, dn, bsy, cnt};
    endfunction

    function automatic logic [15:0] sat(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    // Reference: cycle k after the start edge. A sweep is NG*(d+1) cycles; the run
    // covers sweeps 0..end_sweep, then one FINISH cycle, then idle.
    function automatic logic [22:0] model(input int k, input int d, input int end_sweep);
        int len = NG * (d + 1);
        int r   = (end_sweep + 1) * len;
        int pos;
        if (k < r) begin
            pos = k % len;
            return pack(pos / (d + 1), 1'b1, pos == len - 1, 1'b0, 1'b1, sat(k / len));
        end else if (k == r) begin
            return pack(0, 1'b0, 1'b0, 1'b1, 1'b1, sat(end_sweep + 1));
        end
        return pack(0, 1'b0, 1'b0, 1'b0, 1'b0, sat(end_sweep + 1));
    endfunction

    task automatic sample(input string tag, input logic [22:0] exp);
        check(tag, 32'(observed()), 32'(exp));
        check("grp_range", 32'(bus.group_EN < GROUP_W'(NG)), 32'd1);
        check("valid_implies_busy", 32'(!bus.group_valid || bus.busy), 32'd1);
    endtask

    // One complete run. stop_k: RUN cycle in which stop is pulsed (-1 = never).
    // noise: pulse start while busy and scramble config inputs mid-run.
    task automatic do_run(input string name, input int d, input int n, input int stop_k,
                          input bit stop_with_start, input bit noise);
        int len = NG * (d + 1);
        int es;
        int r;
        if (n == 0) es = stop_k / len;
        else begin
            es = n - 1;
            if (stop_k >= 0 && stop_k / len < es) es = stop_k / len;
        end
        r = (es + 1) * len;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.stop         = stop_with_start;
        bus.dwell_cycles = DWELL_W'(d);
        bus.num_sweeps   = SWEEP_W'(n);
        for (int k = 0; k <= r + 1; k++) begin
            @(negedge clk);
            sample($sformatf("%s k=%0d", name, k), model(k, d, es));
            bus.start = noise && (k <= r) && (k == 2 || $urandom_range(0, 7) == 0);
            bus.stop  = (k == stop_k);
            if (noise) begin
                bus.dwell_cycles = DWELL_W'($urandom);
                bus.num_sweeps   = SWEEP_W'($urandom);
            end
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        rst_n            = 1'b1;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.dwell_cycles = '0;
        bus.num_sweeps   = '0;

        // Reset values, then idle with no start (stray stops must be ignored)
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sample("reset", pack(0, 0, 0, 0, 0, 16'd0));
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sample($sformatf("idle c=%0d", i), pack(0, 0, 0, 0, 0, 16'd0));
            bus.stop = ($urandom_range(0, 3) == 0);
        end
        bus.stop = 1'b0;

        // Directed runs
        do_run("two_sweeps_d0", 0, 2, -1, 1'b0, 1'b0);
        do_run("one_sweep_d2", 2, 1, -1, 1'b0, 1'b0);
        do_run("freerun_stop", 0, 0, 2 * NG + 2, 1'b0, 1'b0);
        do_run("start_stop_busy_start", 1, 3, -1, 1'b1, 1'b1);

        // Reset during group 3 of a run
        @(negedge clk);
        bus.start        = 1'b1;
        bus.dwell_cycles = 8'd1;
        bus.num_sweeps   = 16'd3;
        for (int k = 0; k <= 3 * 2; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            sample($sformatf("pre_rst k=%0d", k), model(k, 1, 2));
        end
        rst_n = 1'b0;
        #1 sample("arst_async", pack(0, 0, 0, 0, 0, 16'd0));
        @(negedge clk);
        sample("arst_hold", pack(0, 0, 0, 0, 0, 16'd0));
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample($sformatf("post_rst c=%0d", i), pack(0, 0, 0, 0, 0, 16'd0));
        end
        do_run("after_rst", 0, 1, -1, 1'b0, 1'b0);

        // Randomized runs
        for (int t = 0; t < 25; t++) begin
            int d;
            int n;
            int len;
            int sk;
            d   = $urandom_range(0, 5);
            n   = $urandom_range(0, 4);
            len = NG * (d + 1);
            if (n == 0) sk = $urandom_range(0, 4 * len - 1);
            else if ($urandom_range(0, 1) == 1) sk = $urandom_range(0, n * len - 1);
            else sk = -1;
            do_run($sformatf("rand%0d d=%0d n=%0d s=%0d", t, d, n, sk), d, n, sk,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
